// File: rtl/dffram_port_arbiter.sv
// Two-port arbiter in front of the single-port mgmt DFFRAM.
// CPU has priority; housekeeping is force-granted after MAX_WAIT denials.
module dffram_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            core_clk,
  input  logic            core_rst,
  input  logic            cpu_req,
  input  logic [DW/8-1:0] cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic            cpu_gnt,
  output logic            cpu_rvalid,
  output logic [DW-1:0]   cpu_rdata,
  input  logic            hk_req,
  input  logic [AW-1:0]   hk_addr,
  output logic            hk_gnt,
  output logic            hk_rvalid,
  output logic [DW-1:0]   hk_rdata,
  output logic            ram_en,
  output logic [DW/8-1:0] ram_we,
  output logic [AW-1:0]   ram_a,
  output logic [DW-1:0]   ram_di,
  input  logic [DW-1:0]   ram_do
);

  localparam int BW = DW / 8;
  localparam int CW = 4;

  typedef enum logic {
    CPU_PRI  = 1'b0,
    HK_FORCE = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_nxt;
  logic          cpu_win;
  logic          hk_win;

  // State register and housekeeping starvation counter
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state    <= CPU_PRI;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Next state: count HK denials, force HK when the bound is hit
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    unique case (state)
      CPU_PRI: begin
        if (hk_req && cpu_req) begin
          wait_nxt = wait_cnt + CW'(1);
          if (wait_nxt == CW'(MAX_WAIT))
            state_nxt = HK_FORCE;
        end else begin
          wait_nxt = '0;
        end
      end
      HK_FORCE: begin
        wait_nxt  = '0;
        state_nxt = CPU_PRI;
      end
      default: begin
        wait_nxt  = '0;
        state_nxt = CPU_PRI;
      end
    endcase
  end

  // Output decode: pick the winner for this cycle
  always_comb begin
    cpu_win = 1'b0;
    hk_win  = 1'b0;
    unique case (state)
      CPU_PRI: begin
        cpu_win = cpu_req;
        hk_win  = hk_req & ~cpu_req;
      end
      HK_FORCE: hk_win = 1'b1;
      default: ;
    endcase
  end

  assign cpu_gnt = cpu_win & ~core_rst;
  assign hk_gnt  = hk_win & ~core_rst;

  assign ram_en = cpu_gnt | hk_gnt;
  assign ram_a  = hk_gnt ? hk_addr : cpu_addr;
  assign ram_we = cpu_gnt ? cpu_we : '0;
  assign ram_di = cpu_wdata;

  assign cpu_rdata = ram_do;
  assign hk_rdata  = ram_do;

  // Read-return strobes, one cycle after the grant
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      cpu_rvalid <= 1'b0;
      hk_rvalid  <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_gnt & (cpu_we == BW'(0));
      hk_rvalid  <= hk_gnt;
    end
  end

endmodule

// File: tb/tb_dffram_port_arbiter.sv
// Directed bench for dffram_port_arbiter with a behavioural DFFRAM.
// Vector table plus hand-written contention and reset sequences.
module tb_dffram_port_arbiter;

  logic        clk;
  logic        core_rst;
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        hk_req;
  logic [7:0]  hk_addr;
  logic        hk_gnt;
  logic        hk_rvalid;
  logic [31:0] hk_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [7:0]  ram_a;
  logic [31:0] ram_di;
  logic [31:0] ram_do;

  int n_vec;
  int n_err;

  dffram_port_arbiter #(
    .AW(8), .DW(32), .MAX_WAIT(4)
  ) dut (
    .core_clk  (clk),
    .core_rst  (core_rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .hk_req    (hk_req),
    .hk_addr   (hk_addr),
    .hk_gnt    (hk_gnt),
    .hk_rvalid (hk_rvalid),
    .hk_rdata  (hk_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_a     (ram_a),
    .ram_di    (ram_di),
    .ram_do    (ram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DFFRAM: data out one cycle after EN
  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 8; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[8'h10] = 32'hDEAD_BEEF;
    mem[8'h20] = 32'hFFFF_FFFF;
    ram_do = 32'h0;
  end
  always @(posedge clk) begin
    if (ram_en) begin
      ram_do = mem[ram_a];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_a][8*b +: 8] = ram_di[8*b +: 8];
    end
  end

  typedef struct {
    logic        cr;
    logic [3:0]  we;
    logic [7:0]  ca;
    logic [31:0] wd;
    logic        hr;
    logic [7:0]  ha;
    logic        ecg;
    logic        ehg;
    logic        ecv;
    logic        ehv;
    logic        dchk;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic cr, logic [3:0] we, logic [7:0] ca,
    logic [31:0] wd, logic hr, logic [7:0] ha,
    logic ecg, logic ehg, logic ecv, logic ehv,
    logic dchk, logic [31:0] ed);
    vec_t v;
    v.cr = cr; v.we = we; v.ca = ca; v.wd = wd;
    v.hr = hr; v.ha = ha; v.ecg = ecg; v.ehg = ehg;
    v.ecv = ecv; v.ehv = ehv; v.dchk = dchk; v.ed = ed;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic cr, logic [3:0] we,
                       logic [7:0] ca, logic [31:0] wd,
                       logic hr, logic [7:0] ha);
    @(negedge clk);
    cpu_req = cr; cpu_we = we; cpu_addr = ca;
    cpu_wdata = wd; hk_req = hr; hk_addr = ha;
    #1;
  endtask

  initial begin
    bit exp_hg;
    bit prev_hg;
    int pulses;
    n_vec = 0;
    n_err = 0;
    core_rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    hk_req = 0; hk_addr = 0;

    // Table: one row per cycle, rvalid/data refer to prior row
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h10, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1,
                      32'hDEAD_BEEF));
    vecs.push_back(mk(1, 4'b0011, 8'h20, 32'h1234_ABCD, 0, 0,
                      1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h20, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,
                      32'hFFFF_ABCD));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 0, 0, 0, 1, 8'(i), 0, 1, 0,
                        i > 0, i > 0,
                        32'hA000_0000 + 32'(i) - 32'd1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,
                      32'hA000_0007));
    vecs.push_back(mk(1, 0, 8'h10, 0, 1, 8'h05, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1,
                      32'hDEAD_BEEF));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state, requests must not be granted under reset
    @(negedge clk); #1;
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_hk_rvalid", 32'(hk_rvalid), 0);
    cpu_req = 1; cpu_we = 4'hF; hk_req = 1; #1;
    chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
    chk("rst_hk_gnt", 32'(hk_gnt), 0);
    chk("rst_ram_en", 32'(ram_en), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    @(negedge clk);
    core_rst = 0; cpu_req = 0; cpu_we = 0; hk_req = 0;

    foreach (vecs[k]) begin
      vec_t v;
      v = vecs[k];
      drive(v.cr, v.we, v.ca, v.wd, v.hr, v.ha);
      chk($sformatf("v%0d_cpu_gnt", k), 32'(cpu_gnt), 32'(v.ecg));
      chk($sformatf("v%0d_hk_gnt", k), 32'(hk_gnt), 32'(v.ehg));
      chk($sformatf("v%0d_cpu_rv", k), 32'(cpu_rvalid), 32'(v.ecv));
      chk($sformatf("v%0d_hk_rv", k), 32'(hk_rvalid), 32'(v.ehv));
      chk($sformatf("v%0d_ram_en", k), 32'(ram_en),
          32'(v.ecg | v.ehg));
      chk($sformatf("v%0d_ram_we", k), 32'(ram_we),
          v.ecg ? 32'(v.we) : 32'h0);
      if (v.ehg)
        chk($sformatf("v%0d_ram_a", k), 32'(ram_a), 32'(v.ha));
      else if (v.ecg)
        chk($sformatf("v%0d_ram_a", k), 32'(ram_a), 32'(v.ca));
      if (v.dchk) begin
        chk($sformatf("v%0d_cpu_rdata", k), cpu_rdata, v.ed);
        chk($sformatf("v%0d_hk_rdata", k), hk_rdata, v.ed);
      end
    end

    // Sustained contention: 4 CPU grants then 1 forced HK grant
    pulses = 0;
    prev_hg = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 8'h10, 0, 1, 8'h00);
      exp_hg = (i % 5 == 4);
      chk($sformatf("con%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(!exp_hg));
      chk($sformatf("con%0d_hk_gnt", i), 32'(hk_gnt), 32'(exp_hg));
      chk($sformatf("con%0d_excl", i), 32'(cpu_gnt & hk_gnt), 0);
      chk($sformatf("con%0d_hk_rv", i), 32'(hk_rvalid), 32'(prev_hg));
      if (hk_rvalid) begin
        pulses++;
        chk($sformatf("con%0d_hk_rdata", i), hk_rdata, 32'hA000_0000);
      end
      prev_hg = exp_hg;
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("con_tail_hk_rv", 32'(hk_rvalid), 1);
    if (hk_rvalid) pulses++;
    chk("con_hk_pulses", 32'(pulses), 4);

    // HK drops its request: starvation count must restart
    drive(1, 0, 8'h10, 0, 1, 8'h01);
    chk("drop0_hk_gnt", 32'(hk_gnt), 0);
    drive(1, 0, 8'h10, 0, 1, 8'h01);
    chk("drop1_hk_gnt", 32'(hk_gnt), 0);
    drive(1, 0, 8'h10, 0, 0, 8'h01);
    chk("drop2_hk_gnt", 32'(hk_gnt), 0);
    chk("drop2_cpu_gnt", 32'(cpu_gnt), 1);
    for (int j = 0; j < 5; j++) begin
      drive(1, 0, 8'h10, 0, 1, 8'h02);
      chk($sformatf("re%0d_hk_gnt", j), 32'(hk_gnt), 32'(j == 4));
      chk($sformatf("re%0d_cpu_gnt", j), 32'(cpu_gnt), 32'(j != 4));
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("re_tail_hk_rdata", hk_rdata, 32'hA000_0002);

    // Reset lands between an HK grant and its data return
    drive(0, 0, 0, 0, 1, 8'h03);
    chk("rmid_hk_gnt", 32'(hk_gnt), 1);
    #2;
    core_rst = 1; cpu_req = 1; cpu_we = 4'hF;
    #1;
    chk("rmid_cpu_gnt", 32'(cpu_gnt), 0);
    chk("rmid_hk_gnt_rst", 32'(hk_gnt), 0);
    chk("rmid_ram_en", 32'(ram_en), 0);
    chk("rmid_ram_we", 32'(ram_we), 0);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk); #1;
      chk($sformatf("rmid%0d_hk_rv", j), 32'(hk_rvalid), 0);
      chk($sformatf("rmid%0d_cpu_rv", j), 32'(cpu_rvalid), 0);
      chk($sformatf("rmid%0d_gnts", j), 32'(cpu_gnt | hk_gnt), 0);
    end
    @(negedge clk);
    core_rst = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    hk_req = 1; hk_addr = 8'h04;
    #1;
    chk("post_cpu_gnt", 32'(cpu_gnt), 1);
    chk("post_hk_gnt", 32'(hk_gnt), 0);
    for (int j = 1; j < 5; j++) begin
      drive(1, 0, 8'h10, 0, 1, 8'h04);
      chk($sformatf("post%0d_hk_gnt", j), 32'(hk_gnt), 32'(j == 4));
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("post_hk_rdata", hk_rdata, 32'hA000_0004);
    chk("post_hk_rv", 32'(hk_rvalid), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
